// File: rtl/branch_predictor.sv
// Bimodal 2-bit branch history table with ID lookup, ID->EX carry, EX grading and training.
// Optional gshare indexing is enabled by defining BPU_GSHARE_EN.
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ID_pc,
    input  logic        ID_Branch,
    input  logic        stall,
    input  logic        flush,
    input  logic        EX_taken,
    output logic [1:0]  ID_branch_prediction,
    output logic        EX_Branch,
    output logic [1:0]  prediction_status,
    output logic        ready
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [IDX_BITS-1:0] IDX_ONE = {{(IDX_BITS-1){1'b0}}, 1'b1};

    typedef enum logic {INIT, RUN} state_t;

    state_t              state, state_nxt;
    logic [IDX_BITS-1:0] cnt;
    logic [1:0]          bht [ENTRIES];

    logic                ex_valid;
    logic [1:0]          ex_pred;
    logic [IDX_BITS-1:0] ex_idx;

    logic [IDX_BITS-1:0] id_idx;
    logic                trn;
    logic [1:0]          ex_ctr, ex_ctr_nxt;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{ID_pc[31:IDX_BITS+2], ID_pc[1:0]};

`ifdef BPU_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    // History moves only on resolved branches, so nothing to repair on flush.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ghr <= '0;
        else if (trn)
            ghr <= (ghr << 1) | GHR_BITS'(EX_taken);
    end

    assign id_idx = ID_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
`else
    assign id_idx = ID_pc[IDX_BITS+1:2];
`endif

    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt == '1)
            state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT)
                cnt <= cnt + IDX_ONE;
        end
    end

    assign trn    = ex_valid && !stall && (state == RUN);
    assign ex_ctr = bht[ex_idx];

    always_comb begin
        ex_ctr_nxt = ex_ctr;
        if (EX_taken && ex_ctr != 2'b11)
            ex_ctr_nxt = ex_ctr + 2'b01;
        else if (!EX_taken && ex_ctr != 2'b00)
            ex_ctr_nxt = ex_ctr - 2'b01;
    end

    // Table has no reset of its own; the INIT sweep fills it with weak-NT.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT)
                bht[cnt] <= 2'b01;
            else if (trn)
                bht[ex_idx] <= ex_ctr_nxt;
        end
    end

    // Bypass keeps back-to-back same-index branches from losing an update.
    always_comb begin
        if (state == INIT)
            ID_branch_prediction = 2'b01;
        else if (trn && ex_idx == id_idx)
            ID_branch_prediction = ex_ctr_nxt;
        else
            ID_branch_prediction = bht[id_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_pred  <= 2'b00;
            ex_idx   <= '0;
        end else if (state == RUN) begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (!stall) begin
                ex_valid <= ID_Branch;
                ex_pred  <= ID_branch_prediction;
                ex_idx   <= id_idx;
            end
        end
    end

    assign EX_Branch = ex_valid;
    assign ready     = (state == RUN);

    always_comb begin
        if (!ex_valid)
            prediction_status = 2'b11;
        else if (ex_pred[1] == EX_taken)
            prediction_status = 2'b10;
        else if (EX_taken)
            prediction_status = 2'b00;
        else
            prediction_status = 2'b01;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default bimodal build).
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ID_pc;
    logic        ID_Branch, stall, flush, EX_taken;
    logic [1:0]  ID_branch_prediction;
    logic        EX_Branch;
    logic [1:0]  prediction_status;
    logic        ready;

    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .ID_pc(ID_pc), .ID_Branch(ID_Branch),
        .stall(stall), .flush(flush), .EX_taken(EX_taken),
        .ID_branch_prediction(ID_branch_prediction), .EX_Branch(EX_Branch),
        .prediction_status(prediction_status), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int n;
        rst_n = 1'b0; ID_pc = '0; ID_Branch = 0; stall = 0; flush = 0; EX_taken = 0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || EX_Branch !== 1'b0 || prediction_status !== 2'b11 || ID_branch_prediction !== 2'b01) begin
            errors++;
            $display("FAIL reset_state: ready=%b ex=%b status=%b pred=%b, want 0 0 11 01",
                     ready, EX_Branch, prediction_status, ID_branch_prediction);
        end
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL init_length: ready after %0d cycles, want 64", n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] pcs [4];
        pcs[0] = 32'h0; pcs[1] = 32'h104; pcs[2] = 32'hFC; pcs[3] = 32'h1234_5678;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ID_pc = pcs[i];
            #1;
            checks++;
            if (ID_branch_prediction !== 2'b01 || prediction_status !== 2'b11) begin
                errors++;
                $display("FAIL reset_lookup pc=%h: pred=%b status=%b, want 01 11",
                         pcs[i], ID_branch_prediction, prediction_status);
            end
        end
    endtask

    task automatic test_training();
        logic [1:0] exp_pred [4];
        logic [1:0] exp_stat [3];
        exp_pred[0] = 2'b01; exp_pred[1] = 2'b10; exp_pred[2] = 2'b11; exp_pred[3] = 2'b11;
        exp_stat[0] = 2'b00; exp_stat[1] = 2'b10; exp_stat[2] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            ID_pc = 32'h100; ID_Branch = 1'b1; EX_taken = 1'b0;
            #1;
            checks++;
            if (ID_branch_prediction !== exp_pred[i]) begin
                errors++;
                $display("FAIL train_pred[%0d]: got %b want %b", i, ID_branch_prediction, exp_pred[i]);
            end
            if (i == 3) break;
            tick();
            ID_Branch = 1'b0; EX_taken = 1'b1;
            #1;
            checks++;
            if (EX_Branch !== 1'b1 || prediction_status !== exp_stat[i]) begin
                errors++;
                $display("FAIL train_status[%0d]: ex=%b status=%b want 1 %b",
                         i, EX_Branch, prediction_status, exp_stat[i]);
            end
            tick();
        end
        ID_Branch = 1'b0;
        tick();
    endtask

    task automatic test_not_taken();
        ID_pc = 32'h100; ID_Branch = 1'b1; EX_taken = 1'b0;
        tick();
        ID_Branch = 1'b0;
        #1;
        checks++;
        if (prediction_status !== 2'b01) begin
            errors++;
            $display("FAIL nt_status: got %b want 01", prediction_status);
        end
        tick();
        #1;
        checks++;
        if (ID_branch_prediction !== 2'b10) begin
            errors++;
            $display("FAIL nt_counter: got %b want 10", ID_branch_prediction);
        end
    endtask

    task automatic test_reset_midrun();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (ready !== 1'b0 || ID_branch_prediction !== 2'b01) begin
            errors++;
            $display("FAIL midrun_init: ready=%b pred=%b want 0 01", ready, ID_branch_prediction);
        end
        for (int n = 0; n < 200 && ready !== 1'b1; n++) tick();
        ID_pc = 32'h100;
        #1;
        checks++;
        if (ready !== 1'b1 || ID_branch_prediction !== 2'b01) begin
            errors++;
            $display("FAIL midrun_restore: ready=%b pred=%b want 1 01", ready, ID_branch_prediction);
        end
    endtask

    task automatic test_bypass();
        ID_pc = 32'h200; ID_Branch = 1'b1; EX_taken = 1'b1;
        #1;
        checks++;
        if (ID_branch_prediction !== 2'b01) begin
            errors++;
            $display("FAIL bypass_first: got %b want 01", ID_branch_prediction);
        end
        tick();
        #1;
        checks++;
        if (ID_branch_prediction !== 2'b10 || prediction_status !== 2'b00) begin
            errors++;
            $display("FAIL bypass_same_cycle: pred=%b status=%b want 10 00",
                     ID_branch_prediction, prediction_status);
        end
        tick();
        ID_Branch = 1'b0;
        #1;
        checks++;
        if (prediction_status !== 2'b10) begin
            errors++;
            $display("FAIL bypass_second_status: got %b want 10", prediction_status);
        end
        tick();
        EX_taken = 1'b0;
        #1;
        checks++;
        if (ID_branch_prediction !== 2'b11 || EX_Branch !== 1'b0) begin
            errors++;
            $display("FAIL bypass_no_lost_update: pred=%b ex=%b want 11 0",
                     ID_branch_prediction, EX_Branch);
        end
    endtask

    task automatic test_stall_flush();
        ID_pc = 32'h104; ID_Branch = 1'b1; EX_taken = 1'b1;
        tick();
        ID_Branch = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (EX_Branch !== 1'b1 || prediction_status !== 2'b00) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ex=%b status=%b want 1 00", i, EX_Branch, prediction_status);
            end
            tick();
        end
        checks++;
        if (ID_branch_prediction !== 2'b01) begin
            errors++;
            $display("FAIL stall_no_train: got %b want 01", ID_branch_prediction);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if (EX_Branch !== 1'b0 || prediction_status !== 2'b11 || ID_branch_prediction !== 2'b01) begin
            errors++;
            $display("FAIL stall_flush: ex=%b status=%b pred=%b want 0 11 01",
                     EX_Branch, prediction_status, ID_branch_prediction);
        end
        // flush alone must not cancel training of the EX branch
        ID_Branch = 1'b1;
        tick();
        ID_Branch = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (EX_Branch !== 1'b0 || ID_branch_prediction !== 2'b10) begin
            errors++;
            $display("FAIL flush_keeps_train: ex=%b pred=%b want 0 10", EX_Branch, ID_branch_prediction);
        end
    endtask

    initial begin
        test_reset();
        test_training();
        test_not_taken();
        test_reset_midrun();
        test_bypass();
        test_stall_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
